// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl
// Buffers one frame of N complex samples, then walks the pairs
// (x[j], x[j+N/2]) through an external registered complex adder, handing
// each sum downstream over a valid/ready handshake.
module fft_stage_ctrl #(
    parameter int N  = 16,
    parameter int DW = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_real,
    input  logic [DW-1:0]           in_imag,
    output logic                    add_valid,
    output logic [DW-1:0]           add_real_a,
    output logic [DW-1:0]           add_imag_a,
    output logic [DW-1:0]           add_real_b,
    output logic [DW-1:0]           add_imag_b,
    input  logic [DW-1:0]           add_real_out,
    input  logic [DW-1:0]           add_imag_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_real,
    output logic [DW-1:0]           out_imag,
    output logic [$clog2(N)-2:0]    out_idx,
    output logic                    frame_done
);

    localparam int AW = $clog2(N);
    localparam int IW = AW - 1;
    localparam logic [AW-1:0] WLAST = AW'(N - 1);
    localparam logic [IW-1:0] JLAST = IW'(N / 2 - 1);

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        OUT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] wcnt;
    logic [IW-1:0] j;

    logic [DW-1:0] sample_re [N];
    logic [DW-1:0] sample_im [N];

    // State register; reset abandons any partial frame immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode, all derived from the registered state
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        add_valid  = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wcnt == WLAST)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                add_valid = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = (j == JLAST) ? DONE : ISSUE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = LOAD;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Write pointer and pair index; the write pointer wraps naturally after N samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            j    <= '0;
        end else begin
            if ((state == LOAD) && in_valid) begin
                wcnt <= wcnt + AW'(1);
            end
            if ((state == OUT) && out_ready) begin
                j <= (j == JLAST) ? '0 : j + IW'(1);
            end
        end
    end

    // Sample buffer is deliberately not reset; every frame rewrites all entries before use
    always_ff @(posedge clk) begin
        if ((state == LOAD) && in_valid) begin
            sample_re[wcnt] <= in_real;
            sample_im[wcnt] <= in_imag;
        end
    end

    assign add_real_a = sample_re[{1'b0, j}];
    assign add_imag_a = sample_im[{1'b0, j}];
    assign add_real_b = sample_re[{1'b1, j}];
    assign add_imag_b = sample_im[{1'b1, j}];

    assign out_real = add_real_out;
    assign out_imag = add_imag_out;
    assign out_idx  = j;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl: directed frames, an external registered
// adder model, and a scoreboard queue drained by an independent monitor.
module tb_fft_stage_ctrl;

    localparam int N    = 16;
    localparam int DW   = 32;
    localparam int HALF = N / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          add_valid;
    logic [DW-1:0] add_real_a;
    logic [DW-1:0] add_imag_a;
    logic [DW-1:0] add_real_b;
    logic [DW-1:0] add_imag_b;
    logic [DW-1:0] add_real_out;
    logic [DW-1:0] add_imag_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic [2:0]    out_idx;
    logic          frame_done;

    typedef struct {
        int            idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_count = 0;
    int            done_cyc = 0;
    int            start_cyc = 0;
    int            ready_mode = 0;
    int            stall_cnt = 0;
    int            results = 0;
    logic [DW-1:0] frame_re [N];
    logic [DW-1:0] frame_im [N];
    bit            hold_valid = 1'b0;
    logic [DW-1:0] hold_re;
    logic [DW-1:0] hold_im;
    logic [2:0]    hold_idx;

    fft_stage_ctrl #(.N(N), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .add_valid    (add_valid),
        .add_real_a   (add_real_a),
        .add_imag_a   (add_imag_a),
        .add_real_b   (add_real_b),
        .add_imag_b   (add_imag_b),
        .add_real_out (add_real_out),
        .add_imag_out (add_imag_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_idx      (out_idx),
        .frame_done   (frame_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for frame latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // External adder: registered, one-cycle latency, holds when not strobed
    always @(posedge clk) begin
        if (add_valid) begin
            add_real_out <= add_real_a + add_real_b;
            add_imag_out <= add_imag_a + add_imag_b;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    // Loads frame_re/frame_im into the DUT, then queues the expected pair sums
    task automatic applyStimulus(input bit gaps, input bit hold_after);
        int   k = 0;
        int   budget = 0;
        exp_t e;
        while (k < N) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_real  = frame_re[k];
            in_imag  = frame_im[k];
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (k == 0) start_cyc = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (budget > 2000) begin
                total++;
                bad++;
                $display("[TB] FAIL load_timeout: got %0d samples, need %0d", k, N);
                break;
            end
        end
        for (int p = 0; p < HALF; p++) begin
            e.idx = p;
            e.re  = frame_re[p] + frame_re[p + HALF];
            e.im  = frame_im[p] + frame_im[p + HALF];
            exp_q.push_back(e);
        end
        if (hold_after) begin
            in_valid = 1'b1;
            in_real  = 32'hDEADBEEF;
            in_imag  = 32'hBAADF00D;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending, need 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generator: normal, stall 5 cycles at idx 2, or park at idx 3
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1 && out_valid && out_idx == 3'd2 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else if (ready_mode == 2 && out_valid && out_idx == 3'd3) begin
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stability under backpressure
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (out_valid || add_valid || frame_done) begin
                    checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
                end
                if (out_valid && !out_ready) begin
                    checkOutput("stall_add_valid", 32'(add_valid), 32'd0);
                    if (hold_valid) begin
                        checkOutput("stall_real", out_real, hold_re);
                        checkOutput("stall_imag", out_imag, hold_im);
                        checkOutput("stall_idx", 32'(out_idx), 32'(hold_idx));
                    end else begin
                        hold_valid = 1'b1;
                        hold_re    = out_real;
                        hold_im    = out_imag;
                        hold_idx   = out_idx;
                    end
                end else begin
                    hold_valid = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_result: got idx %0d, need none", out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("result_idx", 32'(out_idx), 32'(e.idx));
                        checkOutput("result_real", out_real, e.re);
                        checkOutput("result_imag", out_imag, e.im);
                        results++;
                    end
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, need completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence of directed frames
    initial begin
        int n;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b1;

        #2 rst = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_add_valid", 32'(add_valid), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_out_idx", 32'(out_idx), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of the output phase at pair 3
        for (int k = 0; k < N; k++) begin
            frame_re[k] = DW'(k * 10);
            frame_im[k] = DW'(k * 3);
        end
        ready_mode = 2;
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (!(out_valid && out_idx == 3'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_idx3", 32'(out_valid && out_idx == 3'd3), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_add_valid", 32'(add_valid), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_out_idx", 32'(out_idx), 32'd0);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Basic frame x[k] = (k, -k): results (2j+8, -(2j+8)), 33 cycles per frame
        for (int k = 0; k < N; k++) begin
            frame_re[k] = DW'(k);
            frame_im[k] = DW'(-k);
        end
        applyStimulus(1'b0, 1'b0);
        waitIdle();
        checkOutput("frame_cycles", 32'(done_cyc - start_cyc + 1), 32'd33);
        checkOutput("done_after_basic", 32'(done_count), 32'd1);

        // Backpressure: five stalled cycles on pair 2 (value 12)
        stall_cnt  = 0;
        ready_mode = 1;
        applyStimulus(1'b0, 1'b0);
        waitIdle();
        checkOutput("stall_cycles", 32'(stall_cnt), 32'd5);
        ready_mode = 0;

        // Two's complement wrap in the adder
        for (int k = 0; k < N; k++) begin
            frame_re[k] = DW'(k * 3);
            frame_im[k] = DW'(k * 5);
        end
        frame_re[0] = 32'h7FFFFFFF;
        frame_im[0] = 32'h80000000;
        frame_re[8] = 32'h00000001;
        frame_im[8] = 32'hFFFFFFFF;
        applyStimulus(1'b0, 1'b0);
        waitIdle();

        // Back-to-back random-gap frames with in_valid held high during compute
        for (int k = 0; k < N; k++) begin
            frame_re[k] = $urandom;
            frame_im[k] = $urandom;
        end
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            frame_re[k] = $urandom;
            frame_im[k] = $urandom;
        end
        applyStimulus(1'b1, 1'b0);
        waitIdle();

        checkOutput("frame_done_count", 32'(done_count), 32'd5);
        checkOutput("result_count", 32'(results), 32'd43);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for the shared complex adder in an FFT stage. It collects one frame of N complex samples into a local buffer. It then feeds the pairs (x[j], x[j+N/2]) to the external registered adder one pair at a time. Each sum is returned to the downstream stage over a valid/ready handshake.

## Interface
- N, 16, frame length in complex samples; power of two, 4..256
- DW, 32, width of each real/imaginary component (signed, two's complement)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_real, in_imag  in  DW each  input sample components
- add_valid  out  1  adder capture strobe
- add_real_a, add_imag_a  out  DW each  operand a, equal to buf[j]
- add_real_b, add_imag_b  out  DW each  operand b, equal to buf[j+N/2]
- add_real_out, add_imag_out  in  DW each  adder registered result; one-cycle latency; holds its value when add_valid=0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_real, out_imag  out  DW each  result, passed through from the adder
- out_idx  out  log2(N)-1  pair index j of the current result
- frame_done  out  1  one-cycle pulse after the last pair is accepted

## Operation
- States: LOAD, ISSUE, OUT, DONE.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 writes buf[wcnt] and increments wcnt.
  - On the N-th accepted sample, wcnt wraps to 0 and the FSM goes to ISSUE.
- ISSUE:
  - Lasts exactly one cycle. add_valid=1.
  - Operands are driven from buf[j] and buf[j+N/2].
  - Next state is OUT.
- OUT:
  - out_valid=1. out_real/out_imag come directly from the adder outputs. out_idx=j.
  - Stays in OUT while out_ready=0; outputs remain stable.
  - On out_ready=1, if j<N/2-1: j increments and the FSM goes to ISSUE.
  - On out_ready=1, if j=N/2-1: j resets to 0 and the FSM goes to DONE.
- DONE:
  - frame_done=1 for one cycle, then LOAD.
- Outside ISSUE, add_valid=0. Operand outputs always reflect buf at index j.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored; no sample is dropped into the buffer.
- Arithmetic: the controller performs none. Sums wrap modulo 2^DW inside the adder; no saturation and no overflow flag.
- Buffer: N x 2 x DW registers. Contents persist across frames; each frame overwrites every entry before any of it is read.

## Timing
- Reset values:
  - State LOAD, wcnt=0, j=0.
  - in_ready=1.
  - add_valid=0, out_valid=0, frame_done=0, out_idx=0.
  - Operand outputs: whatever buf[0] and buf[N/2] hold; buffer contents are not reset.
- Latency:
  - Last input accepted at edge t. ISSUE runs in cycle t+1. out_valid=1 in cycle t+2.
  - With out_ready held at 1, each pair takes 2 cycles, so a frame takes N + 2·(N/2) + 1 = 2N+1 cycles.
- Handshake:
  - A transfer occurs on a rising edge with valid=1 and ready=1.
  - out_valid never drops without a transfer.
  - out_valid never depends combinationally on out_ready.
- Simultaneous events:
  - out_ready=1 together with the last pair: DONE in the next cycle.
  - in_valid asserted during DONE is ignored. The first sample of the next frame is accepted only in LOAD.
- Reset mid-operation:
  - Takes effect immediately, asynchronously.
  - Any partial frame is abandoned. out_valid and add_valid drop at once.
  - The next frame is loaded starting at buf[0].

## Test plan
- Reset: assert rst mid-OUT at j=3 with N=16 -> out_valid=0 and add_valid=0 immediately; in_ready=1 after release; the next frame restarts at idx 0.
- Basic frame, N=16, x[k]=(k, -k), out_ready=1 -> 8 results idx 0..7.
  - Each result is (2j+8, -(2j+8)).
  - frame_done pulses once; total 33 cycles from the first accepted input.
- Backpressure: hold out_ready=0 for 5 cycles at idx 2 -> out_real/out_imag/out_idx stable; no add_valid pulse; result value 12 is delivered exactly once.
- Wrap-around, DW=32: x[0]=(0x7FFFFFFF, 0x80000000), x[8]=(1, -1) -> idx 0 result is (0x80000000, 0x7FFFFFFF).
- Input gaps and back-to-back frames:
  - Drive in_valid with a random 50% duty; hold in_valid=1 through the compute phase -> no samples accepted while in_ready=0.
  - The second frame's results match a golden model.
  - Also check that frame 2 results are unaffected by frame 1 buffer contents.
